// File: rtl/freq_gate_ctrl.sv
// freq_gate_ctrl: gate-time controller for the frequency counter.
// Counts rising edges of a pre-synchronized signal over a window of exactly
// GATE_CYCLES clocks and holds the count on a valid/ready interface.
// Sequencing: IDLE -> ARM -> GATE -> HOLD -> IDLE (or ARM when restarted).
// Optional build macro FREQ_OVF_FLAG_EN adds the count_ovf saturation flag.
module freq_gate_ctrl #(
    parameter int GATE_CYCLES = 50000000,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sig_sync,
    input  logic             result_ready,
    output logic             busy,
    output logic             gate_open,
    output logic [CNT_W-1:0] count_result,
    output logic             result_valid
`ifdef FREQ_OVF_FLAG_EN
    ,
    output logic             count_ovf
`endif
);

    localparam int GATE_W = $clog2(GATE_CYCLES + 1);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_GATE, S_HOLD} state_t;

    state_t             state_q, state_d;
    logic               sig_d_q, sig_d_d;
    logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic [GATE_W-1:0]  gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]   count_result_q, count_result_d;
    logic               result_valid_q, result_valid_d;
    logic               rise;
    logic               arm_cyc;
    logic               latch_cyc;

    // Saturating increment: the counter sticks at all ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (inc && (v != {CNT_W{1'b1}})) begin
            return v + CNT_W'(1);
        end
        return v;
    endfunction

    assign rise      = sig_sync & ~sig_d_q;
    assign arm_cyc   = (state_q == S_ARM);
    assign latch_cyc = (state_q == S_GATE) && (gate_cnt_q == GATE_LAST);

    assign busy         = (state_q != S_IDLE);
    assign gate_open    = (state_q == S_GATE);
    assign count_result = count_result_q;
    assign result_valid = result_valid_q;

    // Next-state and datapath updates for the measurement sequence.
    always_comb begin
        state_d        = state_q;
        sig_d_d        = sig_sync;
        edge_cnt_d     = edge_cnt_q;
        gate_cnt_d     = gate_cnt_q;
        count_result_d = count_result_q;
        result_valid_d = result_valid_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                // Counters cleared here, so a rise during ARM is never counted.
                edge_cnt_d = '0;
                gate_cnt_d = '0;
                state_d    = S_GATE;
            end
            S_GATE: begin
                gate_cnt_d = gate_cnt_q + GATE_W'(1);
                edge_cnt_d = sat_inc(edge_cnt_q, rise);
                if (latch_cyc) begin
                    // Fold in a rise on the final gate cycle before latching.
                    count_result_d = sat_inc(edge_cnt_q, rise);
                    result_valid_d = 1'b1;
                    state_d        = S_HOLD;
                end
            end
            S_HOLD: begin
                if (result_valid_q && result_ready) begin
                    result_valid_d = 1'b0;
                    state_d        = start ? S_ARM : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; async reset aborts any measurement in flight.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            sig_d_q        <= 1'b0;
            edge_cnt_q     <= '0;
            gate_cnt_q     <= '0;
            count_result_q <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sig_d_q        <= sig_d_d;
            edge_cnt_q     <= edge_cnt_d;
            gate_cnt_q     <= gate_cnt_d;
            count_result_q <= count_result_d;
            result_valid_q <= result_valid_d;
        end
    end

`ifdef FREQ_OVF_FLAG_EN
    logic ovf_int_q, ovf_int_d;
    logic count_ovf_q, count_ovf_d;
    logic edge_full;

    assign edge_full = (edge_cnt_q == {CNT_W{1'b1}});
    assign count_ovf = count_ovf_q;

    // Sticky overflow tracking: cleared in ARM, set by a rise lost to saturation.
    always_comb begin
        ovf_int_d   = ovf_int_q;
        count_ovf_d = count_ovf_q;
        if (arm_cyc) begin
            ovf_int_d = 1'b0;
        end else if (gate_open && rise && edge_full) begin
            ovf_int_d = 1'b1;
        end
        if (latch_cyc) begin
            count_ovf_d = ovf_int_q | (rise & edge_full);
        end
    end

    // Overflow flag registers, held alongside count_result.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            ovf_int_q   <= 1'b0;
            count_ovf_q <= 1'b0;
        end else begin
            ovf_int_q   <= ovf_int_d;
            count_ovf_q <= count_ovf_d;
        end
    end
`endif

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Bench for freq_gate_ctrl: three instances share one stimulus stream
// (GATE=100/CNT_W=8, GATE=100/CNT_W=4, GATE=1/CNT_W=8). Expected counts come
// from a recorded history of sig_sync and a window-counting reference model.
module tb_freq_gate_ctrl;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic sig_sync = 1'b0;
    logic result_ready = 1'b0;

    always #5 clock = ~clock;

    logic       bz [3];
    logic       go [3];
    logic       v  [3];
    logic [31:0] cr [3];
    logic [7:0] cr0;
    logic [3:0] cr1;
    logic [7:0] cr2;
`ifdef FREQ_OVF_FLAG_EN
    logic       ov [3];
`endif

    freq_gate_ctrl #(.GATE_CYCLES(100), .CNT_W(8)) u_g100 (
        .clock(clock), .rst_n(rst_n), .start(start), .sig_sync(sig_sync),
        .result_ready(result_ready), .busy(bz[0]), .gate_open(go[0]),
        .count_result(cr0), .result_valid(v[0])
`ifdef FREQ_OVF_FLAG_EN
        , .count_ovf(ov[0])
`endif
    );

    freq_gate_ctrl #(.GATE_CYCLES(100), .CNT_W(4)) u_w4 (
        .clock(clock), .rst_n(rst_n), .start(start), .sig_sync(sig_sync),
        .result_ready(result_ready), .busy(bz[1]), .gate_open(go[1]),
        .count_result(cr1), .result_valid(v[1])
`ifdef FREQ_OVF_FLAG_EN
        , .count_ovf(ov[1])
`endif
    );

    freq_gate_ctrl #(.GATE_CYCLES(1), .CNT_W(8)) u_g1 (
        .clock(clock), .rst_n(rst_n), .start(start), .sig_sync(sig_sync),
        .result_ready(result_ready), .busy(bz[2]), .gate_open(go[2]),
        .count_result(cr2), .result_valid(v[2])
`ifdef FREQ_OVF_FLAG_EN
        , .count_ovf(ov[2])
`endif
    );

    assign cr[0] = {24'd0, cr0};
    assign cr[1] = {28'd0, cr1};
    assign cr[2] = {24'd0, cr2};

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   c0 = 0;
    int   zero_idx = 0;
    int   sig_mode = 0;
    int   per = 10;
    int   hi = 5;
    int   pulses[$];
    logic hist [0:16383];

    function automatic int glen(input int which);
        return (which == 2) ? 1 : 100;
    endfunction

    function automatic int wmax(input int which);
        return (which == 1) ? 15 : 255;
    endfunction

    // Reference: rises seen on the GATE_CYCLES posedges starting two after start.
    function automatic int raw_count(input int s0, input int g);
        int   n;
        logic prev;
        n = 0;
        for (int k = s0 + 2; k <= s0 + g + 1; k++) begin
            prev = (k == zero_idx) ? 1'b0 : hist[k-1];
            if (hist[k] && !prev) n++;
        end
        return n;
    endfunction

    function automatic int exp_cnt(input int which, input int s0);
        int raw;
        raw = raw_count(s0, glen(which));
        return (raw > wmax(which)) ? wmax(which) : raw;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive sig_sync per mode, record it, return at the negedge.
    task automatic step();
        case (sig_mode)
            1: sig_sync = ((cyc % per) < hi);
            2: sig_sync = 1'($urandom % 2);
            3: begin
                sig_sync = 1'b0;
                foreach (pulses[i]) if ((cyc - c0) == pulses[i]) sig_sync = 1'b1;
            end
            default: sig_sync = 1'b0;
        endcase
        hist[cyc] = sig_sync;
        @(posedge clock);
        cyc++;
        @(negedge clock);
    endtask

    task automatic do_start();
        c0 = cyc;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_valid(input int which, input int pulse_n, input string tag);
        int n;
        int gates;
        n = 0;
        gates = 0;
        while (n < glen(which) + 20) begin
            if (n == pulse_n) start = 1'b1;
            step();
            start = 1'b0;
            n++;
            if (go[which]) gates++;
            if (v[which]) break;
        end
        chk({tag, "_lat"}, n, glen(which) + 1);
        chk({tag, "_gates"}, gates, glen(which));
        chk({tag, "_busy"}, bz[which], 1'b1);
    endtask

    task automatic model_check(input string tag);
        for (int w = 0; w < 2; w++) begin
            chk($sformatf("%s_cnt%0d", tag, w), cr[w], exp_cnt(w, c0));
`ifdef FREQ_OVF_FLAG_EN
            chk($sformatf("%s_ovf%0d", tag, w), ov[w], raw_count(c0, 100) > wmax(w));
`endif
        end
    endtask

    task automatic handshake(input int which, input string tag);
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        chk({tag, "_hs_vld"}, v[which], 1'b0);
        chk({tag, "_hs_busy"}, bz[which], 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        result_ready = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        zero_idx = cyc;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int captured;
        int bad;

        // Reset state
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst_busy", bz[0], 1'b0);
        chk("rst_gate", go[0], 1'b0);
        chk("rst_vld", v[0], 1'b0);
        chk("rst_cnt", cr[0], 0);
        rst_n = 1'b1;
        zero_idx = cyc;

        // Test 1: 10-cycle square wave, 100-cycle gate
        sig_mode = 1; per = 10; hi = 5;
        repeat (15) step();
        do_start();
        chk("t1_arm_busy", bz[0], 1'b1);
        chk("t1_arm_gate", go[0], 1'b0);
        wait_valid(0, -1, "t1");
        chk("t1_cnt0", cr[0], 10);
        chk("t1_cnt1", cr[1], 10);
        handshake(0, "t1");
        chk("t1_keep", cr[0], 10);

        // Test 2: boundary rises (ARM, last gate, HOLD) then (first gate, last gate, HOLD)
        sig_mode = 3;
        pulses = '{1, 101, 103};
        repeat (3) step();
        do_start();
        wait_valid(0, -1, "t2a");
        repeat (4) step();
        chk("t2a_cnt", cr[0], 1);
        chk("t2a_vld", v[0], 1'b1);
        handshake(0, "t2a");
        pulses = '{2, 101, 103};
        repeat (3) step();
        do_start();
        wait_valid(0, -1, "t2b");
        repeat (4) step();
        chk("t2b_cnt", cr[0], 2);
        chk("t2b_cnt_w4", cr[1], 2);
        handshake(0, "t2b");

        // Test 3: random signal, start pulse inside GATE, 20-cycle hold
        sig_mode = 2;
        do_start();
        wait_valid(0, 10, "t3");
        model_check("t3");
        captured = cr[0];
        bad = 0;
        repeat (20) begin
            step();
            if (v[0] !== 1'b1 || cr[0] !== captured || bz[0] !== 1'b1) bad++;
        end
        chk("t3_hold_stable", bad, 0);
        handshake(0, "t3");

        // Test 4: back-to-back measurement, then async reset mid-GATE
        do_start();
        wait_valid(0, -1, "t4a");
        model_check("t4a");
        result_ready = 1'b1;
        start = 1'b1;
        c0 = cyc;
        step();
        start = 1'b0;
        result_ready = 1'b0;
        chk("t4_b2b_vld", v[0], 1'b0);
        chk("t4_b2b_busy", bz[0], 1'b1);
        chk("t4_b2b_gate", go[0], 1'b0);
        wait_valid(0, -1, "t4b");
        model_check("t4b");
        handshake(0, "t4b");
        do_start();
        repeat (30) step();
        rst_n = 1'b0;
        #1;
        chk("t4_rst_busy", bz[0], 1'b0);
        chk("t4_rst_gate", go[0], 1'b0);
        chk("t4_rst_vld", v[0], 1'b0);
        chk("t4_rst_cnt", cr[0], 0);
        repeat (2) step();
        rst_n = 1'b1;
        zero_idx = cyc;
        step();
        chk("t4_post_busy", bz[0], 1'b0);
        chk("t4_post_vld", v[0], 1'b0);

        // Random windows with random consumer delay
        repeat (3) begin
            do_start();
            wait_valid(0, -1, "rnd");
            model_check("rnd");
            repeat ($urandom_range(0, 4)) step();
            handshake(0, "rnd");
        end

        // Test 5: saturation with 20 rises, then 5 rises
        sig_mode = 1; per = 5; hi = 2;
        repeat (5) step();
        do_start();
        wait_valid(0, -1, "t5a");
        chk("t5a_cnt8", cr[0], 20);
        chk("t5a_cnt4", cr[1], 15);
`ifdef FREQ_OVF_FLAG_EN
        chk("t5a_ovf4", ov[1], 1'b1);
        chk("t5a_ovf8", ov[0], 1'b0);
`endif
        handshake(0, "t5a");
        per = 20; hi = 10;
        repeat (20) step();
        do_start();
        wait_valid(0, -1, "t5b");
        chk("t5b_cnt4", cr[1], 5);
`ifdef FREQ_OVF_FLAG_EN
        chk("t5b_ovf4", ov[1], 1'b0);
`endif
        handshake(0, "t5b");

        // Test 6: single-cycle gate
        do_reset();
        sig_mode = 3;
        pulses = '{2};
        repeat (3) step();
        do_start();
        wait_valid(2, -1, "t6a");
        chk("t6a_cnt", cr[2], 1);
        handshake(2, "t6a");
        pulses = '{1, 3};
        repeat (3) step();
        do_start();
        wait_valid(2, -1, "t6b");
        repeat (2) step();
        chk("t6b_cnt", cr[2], 0);
        handshake(2, "t6b");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
